// File: rtl/ff_stim_pkg.sv
// ff_stim_pkg: shared types and helpers for the flip-flop stimulus driver.
// FSM states, drive vector bundle, LFSR taps and seed fixup.
package ff_stim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_EDGE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic d;
    logic clr_n;
    logic set_n;
  } vec_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam vec_t VEC_IDLE  = '{d: 1'b0, clr_n: 1'b1, set_n: 1'b1};
  localparam vec_t VEC_CLEAR = '{d: 1'b0, clr_n: 1'b0, set_n: 1'b1};

  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  function automatic vec_t lfsr_vec(input logic [7:0] l);
    vec_t v;
    v.d     = l[0];
    v.set_n = ~(&l[7:5]);
    v.clr_n = |l[4:2];
    return v;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    logic [7:0] sh;
    sh = l >> 1;
    return l[0] ? (sh ^ LFSR_TAPS) : sh;
  endfunction

endpackage

// File: rtl/ff_stim_lfsr.sv
// ff_stim_lfsr: 8-bit Galois LFSR with synchronous load and advance.
// A zero seed is replaced by 8'h01 so the register never locks up.
module ff_stim_lfsr
  import ff_stim_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (load) begin
      state <= fix_seed(SEED);
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/ff_stim_driver.sv
// ff_stim_driver: drives a D flop with async clear/set and checks q.
// Optional: FF_STIM_STOP_ON_FAIL_EN ends the run at the first mismatch.
module ff_stim_driver
  import ff_stim_pkg::*;
#(
  parameter int         N_VECTORS = 16,
  parameter int         SETTLE    = 2,
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         ERR_W     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             dut_d,
  output logic                             dut_clk,
  output logic                             dut_clr_n,
  output logic                             dut_set_n,
  input  logic                             dut_q,
  output logic                             exp_q,
  output logic                             mismatch,
  output logic [ERR_W-1:0]                 err_cnt,
  output logic [$clog2(N_VECTORS+1)-1:0]   vec_cnt
);

  localparam int VW = $clog2(N_VECTORS + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t        state;
  state_t        next;
  vec_t          vec;
  logic [7:0]    lfsr;
  logic [SW-1:0] set_cnt;
  logic          settle_end;
  logic          last_vec;
  logic          fail_stop;
  logic          model_q;

  ff_stim_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .load   (~rst_n),
    .advance(state == S_APPLY),
    .state  (lfsr)
  );

  assign settle_end = (set_cnt == SW'(SETTLE - 1));
  assign last_vec   = (vec_cnt == VW'(N_VECTORS - 1));
  assign mismatch   = (state == S_CHECK) && (dut_q != exp_q);

`ifdef FF_STIM_STOP_ON_FAIL_EN
  assign fail_stop = mismatch;
`else
  assign fail_stop = 1'b0;
`endif

  // Golden flop: set has priority over clear, both over d.
  assign model_q = !vec.set_n ? 1'b1 :
                   !vec.clr_n ? 1'b0 : vec.d;

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign dut_d     = vec.d;
  assign dut_clr_n = vec.clr_n;
  assign dut_set_n = vec.set_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:   if (start) next = S_APPLY;
      S_APPLY:  next = S_EDGE;
      S_EDGE:   next = S_SETTLE;
      S_SETTLE: if (settle_end) next = S_CHECK;
      S_CHECK:  next = (last_vec || fail_stop) ? S_DONE : S_APPLY;
      S_DONE:   next = S_IDLE;
      default:  next = S_IDLE;
    endcase
  end

  // dut_clk is registered so the generated clock never glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec     <= VEC_IDLE;
      dut_clk <= 1'b0;
      exp_q   <= 1'b0;
      err_cnt <= '0;
      vec_cnt <= '0;
      set_cnt <= '0;
    end else begin
      dut_clk <= (next == S_EDGE) || (next == S_SETTLE) ||
                 (next == S_CHECK);
      if (next == S_APPLY) begin
        vec <= (state == S_IDLE) ? VEC_CLEAR : lfsr_vec(lfsr);
      end else if (next == S_DONE) begin
        vec <= VEC_IDLE;
      end
      if (state == S_EDGE) begin
        exp_q <= model_q;
      end
      set_cnt <= (state == S_SETTLE) ? set_cnt + 1'b1 : '0;
      if (state == S_IDLE && start) begin
        err_cnt <= '0;
        vec_cnt <= '0;
      end
      if (state == S_CHECK) begin
        vec_cnt <= vec_cnt + 1'b1;
        if (mismatch && (err_cnt != '1)) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ff_stim_driver.sv
// tb_ff_stim_driver: directed bench for ff_stim_driver.
// Main instance uses defaults; a second has ERR_W=2, N=6, SETTLE=1, seed 0.
module tb_ff_stim_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic tie0 = 1'b0;

  logic       busy, done, dd, dclk, dclr, dset, expq, mism, q_main;
  logic [7:0] err;
  logic [4:0] vcnt;

  logic       busy2, done2, dd2, dclk2, dclr2, dset2, expq2, mism2, q2;
  logic [1:0] err2;
  logic [2:0] vcnt2;

  logic fq = 1'b0;
  logic fq2 = 1'b0;

  int total = 0;
  int bad = 0;

  // Hand-derived vectors {d,clr_n,set_n} for seed A5, and exp_q per CHECK.
  logic [2:0] vtab [16] = '{3'b001, 3'b010, 3'b111, 3'b001,
                            3'b101, 3'b011, 3'b011, 3'b011,
                            3'b111, 3'b111, 3'b000, 3'b011,
                            3'b011, 3'b011, 3'b011, 3'b111};
  logic [15:0] etab = 16'h8706;

  always #5 clk = ~clk;

  always @(posedge dclk or negedge dclr or negedge dset)
    if (!dset) fq <= 1'b1;
    else if (!dclr) fq <= 1'b0;
    else fq <= dd;

  always @(posedge dclk2 or negedge dclr2 or negedge dset2)
    if (!dset2) fq2 <= 1'b1;
    else if (!dclr2) fq2 <= 1'b0;
    else fq2 <= dd2;

  assign q_main = tie0 ? 1'b0 : fq;
  assign q2 = ~fq2;

  ff_stim_driver u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .dut_d(dd), .dut_clk(dclk),
    .dut_clr_n(dclr), .dut_set_n(dset), .dut_q(q_main),
    .exp_q(expq), .mismatch(mism), .err_cnt(err), .vec_cnt(vcnt)
  );

  ff_stim_driver #(
    .N_VECTORS(6), .SETTLE(1), .SEED(8'h00), .ERR_W(2)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .busy(busy2), .done(done2), .dut_d(dd2), .dut_clk(dclk2),
    .dut_clr_n(dclr2), .dut_set_n(dset2), .dut_q(q2),
    .exp_q(expq2), .mismatch(mism2), .err_cnt(err2), .vec_cnt(vcnt2)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, dclk, dd, dclr, dset, expq, mism} !== 8'b00001100) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=00001100",
               {busy, done, dclk, dd, dclr, dset, expq, mism});
    end
    total++;
    if ({err, vcnt} !== 13'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0h want=0", {err, vcnt});
    end
    total++;
    if ({busy2, dclk2, dclr2, dset2, err2, vcnt2} !== 9'b001100000) begin
      bad++;
      $display("FAIL reset_sat got=%b want=001100000",
               {busy2, dclk2, dclr2, dset2, err2, vcnt2});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    tie0 = 1'b0;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (t % 5 == 0) begin
        total++;
        if ({busy, dclk, dd, dclr, dset} !== {2'b10, vtab[t/5]}) begin
          bad++;
          $display("FAIL run_vec%0d got=%b want=%b", t / 5,
                   {busy, dclk, dd, dclr, dset}, {2'b10, vtab[t/5]});
        end
      end
      if (t % 5 == 4) begin
        total++;
        if ({dclk, expq, mism} !== {1'b1, etab[t/5], 1'b0}) begin
          bad++;
          $display("FAIL run_chk%0d got=%b want=%b", t / 5,
                   {dclk, expq, mism}, {1'b1, etab[t/5], 1'b0});
        end
      end
      @(negedge clk);
    end
    total++;
    if ({done, busy} !== 2'b10) begin
      bad++;
      $display("FAIL run_done80 got=%b want=10", {done, busy});
    end
    total++;
    if (err !== 8'd0 || vcnt !== 5'd16) begin
      bad++;
      $display("FAIL run_counts got=%0d/%0d want=0/16", err, vcnt);
    end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL run_idle got=%b want=00", {done, busy});
    end
  endtask

  task automatic test_tied_low();
    int t;
    int nmis;
    int outside;
    int exp_t;
    int exp_err;
    int exp_vec;
`ifdef FF_STIM_STOP_ON_FAIL_EN
    exp_t = 10; exp_err = 1; exp_vec = 2;
`else
    exp_t = 80; exp_err = 6; exp_vec = 16;
`endif
    tie0 = 1'b1;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0; nmis = 0; outside = 0;
    while (!done && t < 200) begin
      if (mism) begin
        if (t % 5 != 4) outside++;
        else nmis++;
      end
      if (t % 5 == 4 && t < 80) begin
        total++;
        if (mism !== etab[t/5]) begin
          bad++;
          $display("FAIL low_mis%0d got=%b want=%b", t / 5, mism, etab[t/5]);
        end
      end
      t++;
      @(negedge clk);
    end
    total++;
    if (t != exp_t) begin
      bad++;
      $display("FAIL low_len got=%0d want=%0d", t, exp_t);
    end
    total++;
    if (err !== 8'(exp_err) || vcnt !== 5'(exp_vec)) begin
      bad++;
      $display("FAIL low_counts got=%0d/%0d want=%0d/%0d",
               err, vcnt, exp_err, exp_vec);
    end
    total++;
    if (outside != 0 || nmis != exp_err) begin
      bad++;
      $display("FAIL low_pulses got=%0d/%0d want=0/%0d",
               outside, nmis, exp_err);
    end
    tie0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    tie0 = 1'b0;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (27) @(negedge clk);
    total++;
    if ({busy, dclk} !== 2'b11 || vcnt !== 5'd5) begin
      bad++;
      $display("FAIL mid_pre got=%b/%0d want=11/5", {busy, dclk}, vcnt);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, dclk, dclr, dset} !== 5'b00011) begin
      bad++;
      $display("FAIL mid_ctl got=%b want=00011",
               {busy, done, dclk, dclr, dset});
    end
    total++;
    if ({err, vcnt} !== 13'd0) begin
      bad++;
      $display("FAIL mid_cnt got=%0h want=0", {err, vcnt});
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 35; t++) begin
      if (t % 5 == 0) begin
        total++;
        if ({dd, dclr, dset} !== vtab[t/5]) begin
          bad++;
          $display("FAIL rerun_vec%0d got=%b want=%b", t / 5,
                   {dd, dclr, dset}, vtab[t/5]);
        end
      end
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_start_held();
    int dseen;
    int blow;
    tie0 = 1'b0;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    dseen = 0; blow = 0;
    for (int t = 0; t < 80; t++) begin
      if (done) dseen++;
      if (!busy) blow++;
      @(negedge clk);
    end
    total++;
    if (dseen != 0 || blow != 0 || done !== 1'b1) begin
      bad++;
      $display("FAIL held_run got=%0d/%0d/%b want=0/0/1", dseen, blow, done);
    end
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00 || vcnt !== 5'd16) begin
      bad++;
      $display("FAIL held_idle got=%b/%0d want=00/16", {busy, done}, vcnt);
    end
    start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL held_stay got=%b want=0", busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || vcnt !== 5'd0) begin
      bad++;
      $display("FAIL held_new got=%b/%0d want=1/0", busy, vcnt);
    end
    do_reset();
  endtask

  task automatic test_saturate();
    int t;
    int exp_t;
    int exp_err;
    int exp_vec;
`ifdef FF_STIM_STOP_ON_FAIL_EN
    exp_t = 4; exp_err = 1; exp_vec = 1;
`else
    exp_t = 24; exp_err = 3; exp_vec = 6;
`endif
    do_reset();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    t = 0;
    while (!done2 && t < 200) begin
      if (t == 4) begin
        total++;
        if ({dd2, dclr2, dset2} !== 3'b011) begin
          bad++;
          $display("FAIL sat_seed0 got=%b want=011", {dd2, dclr2, dset2});
        end
      end
      t++;
      @(negedge clk);
    end
    total++;
    if (t != exp_t) begin
      bad++;
      $display("FAIL sat_len got=%0d want=%0d", t, exp_t);
    end
    total++;
    if (err2 !== 2'(exp_err) || vcnt2 !== 3'(exp_vec)) begin
      bad++;
      $display("FAIL sat_counts got=%0d/%0d want=%0d/%0d",
               err2, vcnt2, exp_err, exp_vec);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_tied_low();
    test_reset_mid();
    test_start_held();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
